// File: rtl/alu_rs_issue_pkg.sv
// Shared constants for the ALU reservation station: bus widths, NOP op code and tag helpers.
// Build option ALU_RS_AGE_PRIORITY_EN (see alu_rs_issue.sv) does not change anything here.
package alu_rs_issue_pkg;

    localparam int unsigned OPERATION_BUS_W = 4;
    localparam int unsigned ROB_WIDTH       = 4;
    localparam int unsigned DATA_WIDTH      = 32;

    localparam logic [OPERATION_BUS_W-1:0] OP_ZERO = 4'd0;
    localparam logic [OPERATION_BUS_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPERATION_BUS_W-1:0] OP_SUB  = 4'd2;

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic [ROB_WIDTH-1:0]  NO_TAG    = '0;

    // Tag 0 means "value already present", so it never matches a broadcast.
    function automatic logic tag_hit(input logic [ROB_WIDTH-1:0] q,
                                     input logic [ROB_WIDTH-1:0] tag);
        return (q != NO_TAG) && (q == tag);
    endfunction

endpackage

// File: rtl/rs_select.sv
// Combinational priority picker over a request vector: lowest index wins, or, with
// ALU_RS_AGE_PRIORITY_EN defined, the largest age wins with ties going to the lowest index.
module rs_select #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned IDX_W   = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]       i_req,
`ifdef ALU_RS_AGE_PRIORITY_EN
    input  logic [RS_SIZE*IDX_W-1:0] i_age,
`endif
    output logic                     o_found,
    output logic [IDX_W-1:0]         o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;
`ifdef ALU_RS_AGE_PRIORITY_EN
    logic [IDX_W-1:0] w_best;
`endif

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
`ifdef ALU_RS_AGE_PRIORITY_EN
        w_best  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            // Strict '>' keeps the earlier (lower) index on equal age.
            if (i_req[i] && (!w_found || (i_age[i*IDX_W +: IDX_W] > w_best))) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(i);
                w_best  = i_age[i*IDX_W +: IDX_W];
            end
        end
`else
        for (int i = 0; i < RS_SIZE; i++) begin
            if (i_req[i] && !w_found) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(i);
            end
        end
`endif
    end

    assign o_found = w_found;
    assign o_idx   = w_idx;

endmodule

// File: rtl/alu_rs_issue.sv
// ALU reservation station: buffers dispatched ops, snoops both CDBs, issues one ready op per cycle.
// Define ALU_RS_AGE_PRIORITY_EN for oldest-first issue; default is lowest-index-first.
module alu_rs_issue
    import alu_rs_issue_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned IDX_W   = $clog2(RS_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [OPERATION_BUS_W-1:0] in_op,
    input  logic [ROB_WIDTH-1:0]       in_rob_tag,
    input  logic [DATA_WIDTH-1:0]      in_pc,
    input  logic [DATA_WIDTH-1:0]      in_imm,
    input  logic [ROB_WIDTH-1:0]       in_qj,
    input  logic [ROB_WIDTH-1:0]       in_qk,
    input  logic [DATA_WIDTH-1:0]      in_vj,
    input  logic [DATA_WIDTH-1:0]      in_vk,
    output logic                       out_full,
    input  logic [ROB_WIDTH-1:0]       cdb_alu_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_alu_data,
    input  logic [ROB_WIDTH-1:0]       cdb_ls_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_ls_data,
    input  logic                       flush,
    output logic [OPERATION_BUS_W-1:0] out_op,
    output logic [ROB_WIDTH-1:0]       out_rob_tag,
    output logic [DATA_WIDTH-1:0]      out_pc,
    output logic [DATA_WIDTH-1:0]      out_a,
    output logic [DATA_WIDTH-1:0]      out_b,
    output logic [DATA_WIDTH-1:0]      out_imm
);

    logic [RS_SIZE-1:0]         r_busy;
    logic [OPERATION_BUS_W-1:0] r_op  [RS_SIZE];
    logic [ROB_WIDTH-1:0]       r_rob [RS_SIZE];
    logic [DATA_WIDTH-1:0]      r_pc  [RS_SIZE];
    logic [DATA_WIDTH-1:0]      r_imm [RS_SIZE];
    logic [ROB_WIDTH-1:0]       r_qj  [RS_SIZE];
    logic [DATA_WIDTH-1:0]      r_vj  [RS_SIZE];
    logic [ROB_WIDTH-1:0]       r_qk  [RS_SIZE];
    logic [DATA_WIDTH-1:0]      r_vk  [RS_SIZE];

    logic [OPERATION_BUS_W-1:0] r_out_op;
    logic [ROB_WIDTH-1:0]       r_out_rob;
    logic [DATA_WIDTH-1:0]      r_out_pc;
    logic [DATA_WIDTH-1:0]      r_out_a;
    logic [DATA_WIDTH-1:0]      r_out_b;
    logic [DATA_WIDTH-1:0]      r_out_imm;

    logic [RS_SIZE-1:0]    w_ready;
    logic                  w_iss_found;
    logic [IDX_W-1:0]      w_iss_idx;
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_dispatch;
    logic [ROB_WIDTH-1:0]  w_in_qj;
    logic [DATA_WIDTH-1:0] w_in_vj;
    logic [ROB_WIDTH-1:0]  w_in_qk;
    logic [DATA_WIDTH-1:0] w_in_vk;

`ifdef ALU_RS_AGE_PRIORITY_EN
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_SIZE - 1);

    logic [IDX_W-1:0]         r_age [RS_SIZE];
    logic [RS_SIZE*IDX_W-1:0] w_age_flat;

    always_comb begin
        w_age_flat = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_age_flat[i*IDX_W +: IDX_W] = r_age[i];
        end
    end
`endif

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] && (r_qj[i] == NO_TAG) && (r_qk[i] == NO_TAG);
        end
    end

    rs_select #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_issue_sel (
        .i_req   (w_ready),
`ifdef ALU_RS_AGE_PRIORITY_EN
        .i_age   (w_age_flat),
`endif
        .o_found (w_iss_found),
        .o_idx   (w_iss_idx)
    );

    // Free-slot search: same picker, ages forced equal so the lowest free index wins.
    rs_select #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_free_sel (
        .i_req   (~r_busy),
`ifdef ALU_RS_AGE_PRIORITY_EN
        .i_age   ('0),
`endif
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    // Operands already being broadcast this cycle are captured directly at dispatch.
    always_comb begin
        w_in_qj = in_qj;
        w_in_vj = in_vj;
        w_in_qk = in_qk;
        w_in_vk = in_vk;
        if (tag_hit(in_qj, cdb_alu_tag)) begin
            w_in_qj = NO_TAG;
            w_in_vj = cdb_alu_data;
        end else if (tag_hit(in_qj, cdb_ls_tag)) begin
            w_in_qj = NO_TAG;
            w_in_vj = cdb_ls_data;
        end
        if (tag_hit(in_qk, cdb_alu_tag)) begin
            w_in_qk = NO_TAG;
            w_in_vk = cdb_alu_data;
        end else if (tag_hit(in_qk, cdb_ls_tag)) begin
            w_in_qk = NO_TAG;
            w_in_vk = cdb_ls_data;
        end
    end

    assign out_full   = &r_busy;
    assign w_dispatch = in_valid && w_free_found && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_out_op  <= OP_ZERO;
            r_out_rob <= NO_TAG;
            r_out_pc  <= ZERO_DATA;
            r_out_a   <= ZERO_DATA;
            r_out_b   <= ZERO_DATA;
            r_out_imm <= ZERO_DATA;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    if (tag_hit(r_qj[i], cdb_alu_tag)) begin
                        r_qj[i] <= NO_TAG;
                        r_vj[i] <= cdb_alu_data;
                    end else if (tag_hit(r_qj[i], cdb_ls_tag)) begin
                        r_qj[i] <= NO_TAG;
                        r_vj[i] <= cdb_ls_data;
                    end
                    if (tag_hit(r_qk[i], cdb_alu_tag)) begin
                        r_qk[i] <= NO_TAG;
                        r_vk[i] <= cdb_alu_data;
                    end else if (tag_hit(r_qk[i], cdb_ls_tag)) begin
                        r_qk[i] <= NO_TAG;
                        r_vk[i] <= cdb_ls_data;
                    end
                end
            end

            if (flush) begin
                r_busy    <= '0;
                r_out_op  <= OP_ZERO;
                r_out_rob <= NO_TAG;
                r_out_pc  <= ZERO_DATA;
                r_out_a   <= ZERO_DATA;
                r_out_b   <= ZERO_DATA;
                r_out_imm <= ZERO_DATA;
            end else begin
                if (w_iss_found) begin
                    r_busy[w_iss_idx] <= 1'b0;
                    r_out_op  <= r_op[w_iss_idx];
                    r_out_rob <= r_rob[w_iss_idx];
                    r_out_pc  <= r_pc[w_iss_idx];
                    r_out_a   <= r_vj[w_iss_idx];
                    r_out_b   <= r_vk[w_iss_idx];
                    r_out_imm <= r_imm[w_iss_idx];
                end else begin
                    r_out_op  <= OP_ZERO;
                    r_out_rob <= NO_TAG;
                    r_out_pc  <= ZERO_DATA;
                    r_out_a   <= ZERO_DATA;
                    r_out_b   <= ZERO_DATA;
                    r_out_imm <= ZERO_DATA;
                end

                // The free slot is never busy, so it cannot collide with the snoop or issue above.
                if (w_dispatch) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_op[w_free_idx]   <= in_op;
                    r_rob[w_free_idx]  <= in_rob_tag;
                    r_pc[w_free_idx]   <= in_pc;
                    r_imm[w_free_idx]  <= in_imm;
                    r_qj[w_free_idx]   <= w_in_qj;
                    r_vj[w_free_idx]   <= w_in_vj;
                    r_qk[w_free_idx]   <= w_in_qk;
                    r_vk[w_free_idx]   <= w_in_vk;
`ifdef ALU_RS_AGE_PRIORITY_EN
                    for (int i = 0; i < RS_SIZE; i++) begin
                        if ((IDX_W'(i) != w_free_idx) && r_busy[i] && (r_age[i] != AGE_MAX)) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end
                    r_age[w_free_idx] <= '0;
`endif
                end
            end
        end
    end

    assign out_op      = r_out_op;
    assign out_rob_tag = r_out_rob;
    assign out_pc      = r_out_pc;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_imm     = r_out_imm;

endmodule

// File: tb/tb_alu_rs_issue.sv
// Directed bench for alu_rs_issue: a per-cycle vector table plus hand-written full/flush/age
// sequences. Expected issue order in the age sequence follows ALU_RS_AGE_PRIORITY_EN.
module tb_alu_rs_issue;
    import alu_rs_issue_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic [OPERATION_BUS_W-1:0] in_op;
    logic [ROB_WIDTH-1:0]       in_rob_tag;
    logic [DATA_WIDTH-1:0]      in_pc;
    logic [DATA_WIDTH-1:0]      in_imm;
    logic [ROB_WIDTH-1:0]       in_qj;
    logic [ROB_WIDTH-1:0]       in_qk;
    logic [DATA_WIDTH-1:0]      in_vj;
    logic [DATA_WIDTH-1:0]      in_vk;
    logic                       out_full;
    logic [ROB_WIDTH-1:0]       cdb_alu_tag;
    logic [DATA_WIDTH-1:0]      cdb_alu_data;
    logic [ROB_WIDTH-1:0]       cdb_ls_tag;
    logic [DATA_WIDTH-1:0]      cdb_ls_data;
    logic                       flush;
    logic [OPERATION_BUS_W-1:0] out_op;
    logic [ROB_WIDTH-1:0]       out_rob_tag;
    logic [DATA_WIDTH-1:0]      out_pc;
    logic [DATA_WIDTH-1:0]      out_a;
    logic [DATA_WIDTH-1:0]      out_b;
    logic [DATA_WIDTH-1:0]      out_imm;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs_issue #(.RS_SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_rob_tag   (in_rob_tag),
        .in_pc        (in_pc),
        .in_imm       (in_imm),
        .in_qj        (in_qj),
        .in_qk        (in_qk),
        .in_vj        (in_vj),
        .in_vk        (in_vk),
        .out_full     (out_full),
        .cdb_alu_tag  (cdb_alu_tag),
        .cdb_alu_data (cdb_alu_data),
        .cdb_ls_tag   (cdb_ls_tag),
        .cdb_ls_data  (cdb_ls_data),
        .flush        (flush),
        .out_op       (out_op),
        .out_rob_tag  (out_rob_tag),
        .out_pc       (out_pc),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_imm      (out_imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [3:0]  alu_tag;
        logic [31:0] alu_data;
        logic [3:0]  ls_tag;
        logic [31:0] ls_data;
        logic [3:0]  e_op;
        logic [3:0]  e_tag;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // pc/imm are derived from the ROB tag at dispatch, so an issue of tag t must carry them back.
    task automatic chk_out(input string name, input logic [3:0] e_op, input logic [3:0] e_tag,
                           input logic [31:0] e_a, input logic [31:0] e_b);
        chk({name, ".op"},  32'(out_op),      32'(e_op));
        chk({name, ".tag"}, 32'(out_rob_tag), 32'(e_tag));
        chk({name, ".a"},   out_a, e_a);
        chk({name, ".b"},   out_b, e_b);
        chk({name, ".pc"},  out_pc,  (e_tag == 4'd0) ? 32'd0 : 32'h1000 + 32'(e_tag));
        chk({name, ".imm"}, out_imm, (e_tag == 4'd0) ? 32'd0 : 32'h0200 + 32'(e_tag));
    endtask

    task automatic chk_idle(input string name);
        chk_out(name, OP_ZERO, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] tag,
                         input logic [3:0] qj, input logic [31:0] vj,
                         input logic [3:0] qk, input logic [31:0] vk);
        in_valid   = v;
        in_op      = op;
        in_rob_tag = tag;
        in_pc      = 32'h1000 + 32'(tag);
        in_imm     = 32'h0200 + 32'(tag);
        in_qj      = qj;
        in_vj      = vj;
        in_qk      = qk;
        in_vk      = vk;
    endtask

    task automatic cdb(input logic [3:0] at, input logic [31:0] ad,
                       input logic [3:0] lt, input logic [31:0] ld);
        cdb_alu_tag  = at;
        cdb_alu_data = ad;
        cdb_ls_tag   = lt;
        cdb_ls_data  = ld;
    endtask

    task automatic idle();
        drive(1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0);
        cdb(4'd0, 32'd0, 4'd0, 32'd0);
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {valid, op, tag, qj, vj, qk, vk, alu_tag, alu_data, ls_tag, ls_data, e_op, e_tag, e_a, e_b}
        tbl[0] = '{1'b1, OP_ADD, 4'd3, 4'd0, 32'd5, 4'd0, 32'd7, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};
        tbl[1] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ADD, 4'd3, 32'd5, 32'd7};
        tbl[2] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};
        tbl[3] = '{1'b1, OP_SUB, 4'd4, 4'd2, 32'd0, 4'd0, 32'd1, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};
        tbl[4] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};
        tbl[5] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd2, 32'h10, 4'd0, 32'd0,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};
        tbl[6] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_SUB, 4'd4, 32'h10, 32'd1};
        tbl[7] = '{1'b1, OP_ADD, 4'd5, 4'd0, 32'd3, 4'd6, 32'd0, 4'd0, 32'd0, 4'd6, 32'hAB,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};
        tbl[8] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ADD, 4'd5, 32'd3, 32'hAB};
        tbl[9] = '{1'b0, OP_ZERO, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0,
                   OP_ZERO, 4'd0, 32'd0, 32'd0};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        chk("reset.full", 32'(out_full), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].tag, tbl[i].qj, tbl[i].vj, tbl[i].qk, tbl[i].vk);
            cdb(tbl[i].alu_tag, tbl[i].alu_data, tbl[i].ls_tag, tbl[i].ls_data);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].e_op, tbl[i].e_tag, tbl[i].e_a, tbl[i].e_b);
            chk($sformatf("vec%0d.full", i), 32'(out_full), 32'd0);
        end

        // Fill every entry with ops waiting on tag 9.
        for (int k = 0; k < 8; k++) begin
            idle();
            drive(1'b1, OP_ADD, 4'(k + 1), 4'd9, 32'd0, 4'd0, 32'h20 + 32'(k));
            tick();
            chk_idle($sformatf("fill%0d", k));
            chk($sformatf("fill%0d.full", k), 32'(out_full), (k == 7) ? 32'd1 : 32'd0);
        end
        idle();
        drive(1'b1, OP_ADD, 4'd10, 4'd0, 32'd1, 4'd0, 32'd2);
        tick();
        chk_idle("ninth");
        chk("ninth.full", 32'(out_full), 32'd1);
        idle();
        cdb(4'd9, 32'h99, 4'd0, 32'd0);
        tick();
        chk_idle("wake9");
        chk("wake9.full", 32'(out_full), 32'd1);
        for (int k = 0; k < 8; k++) begin
            idle();
            // Dispatch while full with an issue pending: must still be refused.
            if (k == 0) drive(1'b1, OP_ADD, 4'd11, 4'd0, 32'd3, 4'd0, 32'd4);
            tick();
            chk_out($sformatf("drain%0d", k), OP_ADD, 4'(k + 1), 32'h99, 32'h20 + 32'(k));
            chk($sformatf("drain%0d.full", k), 32'(out_full), 32'd0);
        end
        idle();
        tick();
        chk_idle("drain_end");

        // Flush with three busy entries, one of them ready to issue at the flush edge.
        idle();
        drive(1'b1, OP_ADD, 4'd1, 4'd12, 32'd0, 4'd0, 32'd0);
        tick();
        drive(1'b1, OP_ADD, 4'd2, 4'd12, 32'd0, 4'd0, 32'd0);
        tick();
        drive(1'b1, OP_ADD, 4'd3, 4'd0, 32'd5, 4'd0, 32'd6);
        tick();
        chk_idle("pre_flush");
        drive(1'b1, OP_SUB, 4'd13, 4'd0, 32'd7, 4'd0, 32'd8);
        flush = 1'b1;
        tick();
        chk_idle("flush");
        chk("flush.full", 32'(out_full), 32'd0);
        idle();
        cdb(4'd12, 32'h55, 4'd0, 32'd0);
        tick();
        chk_idle("post_flush0");
        idle();
        tick();
        chk_idle("post_flush1");
        tick();
        chk_idle("post_flush2");

        // Age: B ready in entry 0, A waits in entry 1, C reuses entry 0, then A and C wake together.
        idle();
        drive(1'b1, OP_ADD, 4'd1, 4'd0, 32'd1, 4'd0, 32'd2);
        tick();
        chk_idle("age_b");
        drive(1'b1, OP_SUB, 4'd2, 4'd14, 32'd0, 4'd0, 32'd3);
        tick();
        chk_out("age_b_issue", OP_ADD, 4'd1, 32'd1, 32'd2);
        drive(1'b1, OP_ADD, 4'd3, 4'd14, 32'd0, 4'd0, 32'd4);
        tick();
        chk_idle("age_c");
        idle();
        cdb(4'd14, 32'h40, 4'd0, 32'd0);
        tick();
        chk_idle("age_wake");
        idle();
        tick();
`ifdef ALU_RS_AGE_PRIORITY_EN
        chk_out("age_first", OP_SUB, 4'd2, 32'h40, 32'd3);
        tick();
        chk_out("age_second", OP_ADD, 4'd3, 32'h40, 32'd4);
`else
        chk_out("age_first", OP_ADD, 4'd3, 32'h40, 32'd4);
        tick();
        chk_out("age_second", OP_SUB, 4'd2, 32'h40, 32'd3);
`endif
        tick();
        chk_idle("age_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
